// File: rtl/seg7_pkg.sv
// Shared seven-segment encodings and helpers for the scanned display driver.
// Segment vectors are ordered {g,f,e,d,c,b,a} and are active-high in this package.
package seg7_pkg;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_DASH  = 7'h40;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CONV = 1'b1
    } conv_state_e;

    // Used at elaboration for the overflow threshold.
    function automatic longint unsigned pow10(input int n);
        longint unsigned r;
        r = 1;
        for (int i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

    // Non-decimal nibbles never reach here in normal operation; show them blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        case (nib)
            4'd0:    return SEG_DIGIT[0];
            4'd1:    return SEG_DIGIT[1];
            4'd2:    return SEG_DIGIT[2];
            4'd3:    return SEG_DIGIT[3];
            4'd4:    return SEG_DIGIT[4];
            4'd5:    return SEG_DIGIT[5];
            4'd6:    return SEG_DIGIT[6];
            4'd7:    return SEG_DIGIT[7];
            4'd8:    return SEG_DIGIT[8];
            4'd9:    return SEG_DIGIT[9];
            default: return SEG_BLANK;
        endcase
    endfunction

    function automatic logic [6:0] seg_polarity(input logic [6:0] s, input bit active_low);
        return active_low ? ~s : s;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3, one input bit per cycle).
// done pulses during the last conversion cycle, with bcd/ovf valid alongside it.
module bin2bcd_seq
    import seg7_pkg::*;
#(
    parameter int VALUE_W = 14,
    parameter int DIGITS  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [VALUE_W-1:0]    bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(VALUE_W + 1);
    localparam longint unsigned OVF_LIMIT = pow10(DIGITS);

    conv_state_e          state_q, state_d;
    logic [VALUE_W-1:0]   bin_q, bin_d;
    logic [BCD_W-1:0]     bcd_q, bcd_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;
    logic [BCD_W-1:0]     shifted;

    // Adjust-and-shift in one step. The top nibble only keeps three bits because
    // its carry out would be a digit above DIGITS, which is discarded.
    assign shifted[0] = bin_q[VALUE_W-1];

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
            logic [3:0] nib;
            logic       add3;
            assign nib  = bcd_q[4*gi +: 4];
            assign add3 = (nib >= 4'd5);
            if (gi == DIGITS - 1) begin : g_top
                assign shifted[4*gi+1 +: 3] = nib[2:0] + (add3 ? 3'd3 : 3'd0);
            end else begin : g_mid
                assign shifted[4*gi+1 +: 4] = nib + (add3 ? 4'd3 : 4'd0);
            end
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CONV;
                    bin_d   = bin;
                    bcd_d   = '0;
                    cnt_d   = CNT_W'(VALUE_W);
                    ovf_d   = (64'(bin) >= OVF_LIMIT);
                end
            end
            CONV: begin
                bin_d = bin_q << 1;
                bcd_d = shifted;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = IDLE;
                    done    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == CONV);
    assign bcd  = shifted;
    assign ovf  = ovf_q;

endmodule

// File: rtl/scan_display_driver.sv
// Multiplexed seven-segment driver: converts a loaded value to BCD, then scans
// the digits with leading-zero blanking and a dash pattern on overflow.
module scan_display_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int VALUE_W    = 14,
    parameter int SCAN_DIV   = 50000,
    parameter bit BLANK_LZ   = 1'b1,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [VALUE_W-1:0]  value,
    input  logic                load,
    output logic                busy,
    output logic                overflow,
    output logic [6:0]          seg,
    output logic [DIGITS-1:0]   dig_en
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int DIV_W = $clog2(SCAN_DIV);

    logic               conv_busy;
    logic               conv_done;
    logic [BCD_W-1:0]   conv_bcd;
    logic               conv_ovf;

    logic [BCD_W-1:0]   disp_q, disp_d;
    logic               overflow_q, overflow_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [6:0]         seg_q, seg_d;
    logic [DIGITS-1:0]  dig_en_q, dig_en_d;

    logic [6:0]         digit_seg [DIGITS];
    logic [DIGITS-1:0]  onehot;

    bin2bcd_seq #(
        .VALUE_W (VALUE_W),
        .DIGITS  (DIGITS)
    ) u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (load),
        .bin   (value),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd),
        .ovf   (conv_ovf)
    );

    // Display contents change only on conversion completion, so the scan
    // never sees an intermediate shift-register value.
    always_comb begin
        disp_d     = disp_q;
        overflow_d = overflow_q;
        if (conv_done) begin
            disp_d     = conv_bcd;
            overflow_d = conv_ovf;
        end
    end

    // Walk from the most significant digit down, tracking whether any nonzero
    // digit has been seen yet; digit 0 always shows.
    always_comb begin
        logic       any_nz;
        logic [3:0] nib;
        any_nz = 1'b0;
        nib    = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            nib    = disp_q[4*i +: 4];
            any_nz = any_nz | (nib != 4'd0);
            if (overflow_q) begin
                digit_seg[i] = SEG_DASH;
            end else if (BLANK_LZ && (i != 0) && !any_nz) begin
                digit_seg[i] = SEG_BLANK;
            end else begin
                digit_seg[i] = seg_decode(nib);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_onehot
            assign onehot[gi] = (idx_q == IDX_W'(gi));
        end
    endgenerate

    always_comb begin
        div_d = div_q + DIV_W'(1);
        idx_d = idx_q;
        if (div_q == DIV_W'(SCAN_DIV - 1)) begin
            div_d = '0;
            idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
        seg_d    = seg_polarity(digit_seg[idx_q], ACTIVE_LOW);
        dig_en_d = ACTIVE_LOW ? ~onehot : onehot;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            disp_q     <= '0;
            overflow_q <= 1'b0;
            div_q      <= '0;
            idx_q      <= '0;
            seg_q      <= seg_polarity(SEG_BLANK, ACTIVE_LOW);
            dig_en_q   <= ACTIVE_LOW ? '1 : '0;
        end else begin
            disp_q     <= disp_d;
            overflow_q <= overflow_d;
            div_q      <= div_d;
            idx_q      <= idx_d;
            seg_q      <= seg_d;
            dig_en_q   <= dig_en_d;
        end
    end

    assign busy     = conv_busy;
    assign overflow = overflow_q;
    assign seg      = seg_q;
    assign dig_en   = dig_en_q;

endmodule

// File: tb/tb_scan_display_driver.sv
// Scoreboard bench for scan_display_driver: one instance blanks leading zeros,
// the other shows all digits; both see identical stimulus.
module tb_scan_display_driver;

    localparam int DIGITS   = 4;
    localparam int VALUE_W  = 14;
    localparam int SCAN_DIV = 4;
    localparam int CONV_LEN = VALUE_W;

    logic               clk = 1'b0;
    logic               rst;
    logic               load;
    logic [VALUE_W-1:0] value;
    logic               busy, busy_nb;
    logic               overflow, overflow_nb;
    logic [6:0]         seg, seg_nb;
    logic [DIGITS-1:0]  dig_en, dig_en_nb;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    scan_display_driver #(
        .DIGITS(DIGITS), .VALUE_W(VALUE_W), .SCAN_DIV(SCAN_DIV),
        .BLANK_LZ(1'b1), .ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .value(value), .load(load),
        .busy(busy), .overflow(overflow), .seg(seg), .dig_en(dig_en)
    );

    scan_display_driver #(
        .DIGITS(DIGITS), .VALUE_W(VALUE_W), .SCAN_DIV(SCAN_DIV),
        .BLANK_LZ(1'b0), .ACTIVE_LOW(1'b1)
    ) dut_nb (
        .clk(clk), .rst(rst), .value(value), .load(load),
        .busy(busy_nb), .overflow(overflow_nb), .seg(seg_nb), .dig_en(dig_en_nb)
    );

    typedef struct {
        int val;
        bit ovf;
    } exp_t;

    exp_t exp_q[$];
    int   cur_val;
    bit   cur_ovf;
    int   last_acc;
    int   checks = 0;
    int   errors = 0;

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Active-high expected pattern for digit d of value v.
    function automatic logic [6:0] model_seg(input int v, input bit ovf, input int d, input bit blank_lz);
        int p;
        p = 1;
        for (int i = 0; i < d; i++) p = p * 10;
        if (ovf) return 7'h40;
        if (blank_lz && d > 0 && v < p) return 7'h00;
        return seg_tab[(v / p) % 10];
    endfunction

    // -1: all digits off, -2: not a valid one-hot-low pattern.
    function automatic int active_digit(input logic [3:0] en);
        logic [3:0] pat;
        if (en === 4'hF) return -1;
        for (int d = 0; d < DIGITS; d++) begin
            pat = 4'b0001 << d;
            pat = ~pat;
            if (en === pat) return d;
        end
        return -2;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        cur_val  = 0;
        cur_ovf  = 1'b0;
        last_acc = -1000;
    endtask

    // Called at a negedge; the strobe is sampled on the next rising edge.
    task automatic drive_load(input int v);
        bit acc;
        value = VALUE_W'(v);
        load  = 1'b1;
        acc   = (cyc + 1 >= last_acc + CONV_LEN + 1);
        if (acc) begin
            exp_q.push_back('{v, (v >= 10000)});
            last_acc = cyc + 1;
        end
        $display("load value=%0d edge=%0d accepted=%0d", v, cyc + 1, acc);
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_len);
        int   n;
        exp_t e;
        n = 0;
        while (busy === 1'b1 && n < 60) begin
            n++;
            @(negedge clk);
        end
        check_eq({tag, "_busy_len"}, n, exp_len);
        check_eq({tag, "_busy_nb_end"}, busy_nb, 1'b0);
        if (exp_q.size() > 0) begin
            e       = exp_q.pop_front();
            cur_val = e.val;
            cur_ovf = e.ovf;
        end
        check_eq({tag, "_ovf"}, overflow, cur_ovf);
        check_eq({tag, "_ovf_nb"}, overflow_nb, cur_ovf);
        $display("result %s value=%0d ovf=%0d busy_cycles=%0d", tag, cur_val, cur_ovf, n);
    endtask

    // Observe one full scan period on both instances and check every digit once.
    task automatic check_display(input string tag);
        bit         seen [DIGITS];
        bit         seen_nb [DIGITS];
        int         bad, nseen, nseen_nb, d;
        logic [6:0] exp_s;
        for (int i = 0; i < DIGITS; i++) begin
            seen[i]    = 1'b0;
            seen_nb[i] = 1'b0;
        end
        bad = 0;
        @(negedge clk);
        for (int c = 0; c < DIGITS * SCAN_DIV + 4; c++) begin
            d = active_digit(dig_en);
            if (d == -2) bad++;
            if (d >= 0 && !seen[d]) begin
                exp_s = ~model_seg(cur_val, cur_ovf, d, 1'b1);
                check_eq($sformatf("%s_seg_d%0d", tag, d), seg, exp_s);
                seen[d] = 1'b1;
            end
            d = active_digit(dig_en_nb);
            if (d == -2) bad++;
            if (d >= 0 && !seen_nb[d]) begin
                exp_s = ~model_seg(cur_val, cur_ovf, d, 1'b0);
                check_eq($sformatf("%s_segnb_d%0d", tag, d), seg_nb, exp_s);
                seen_nb[d] = 1'b1;
            end
            @(negedge clk);
        end
        nseen    = 0;
        nseen_nb = 0;
        for (int i = 0; i < DIGITS; i++) begin
            nseen    += int'(seen[i]);
            nseen_nb += int'(seen_nb[i]);
        end
        check_eq({tag, "_digits_seen"}, nseen, DIGITS);
        check_eq({tag, "_digits_seen_nb"}, nseen_nb, DIGITS);
        check_eq({tag, "_onehot"}, bad, 0);
        $display("display %s value=%0d ovf=%0d", tag, cur_val, cur_ovf);
    endtask

    // Scan order and dwell time, from the first enabled digit after reset.
    task automatic scan_order();
        logic [3:0] prev, rot;
        int         run, transitions;
        prev        = dig_en;
        run         = 1;
        transitions = 0;
        for (int c = 0; c < 10 * SCAN_DIV; c++) begin
            @(negedge clk);
            if (dig_en === prev) begin
                run++;
            end else begin
                if (prev !== 4'hF) begin
                    rot = {prev[2:0], prev[3]};
                    check_eq("scan_rot", dig_en, rot);
                    if (transitions > 0) check_eq("scan_len", run, SCAN_DIV);
                    transitions++;
                end
                run  = 1;
                prev = dig_en;
            end
        end
        check_eq("scan_transitions", transitions, 9);
        $display("scan transitions=%0d", transitions);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst   = 1'b1;
        load  = 1'b0;
        value = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_ovf", overflow, 1'b0);
        check_eq("rst_seg", seg, 7'h7F);
        check_eq("rst_dig_en", dig_en, 4'hF);
        check_eq("rst_seg_nb", seg_nb, 7'h7F);
        check_eq("rst_dig_en_nb", dig_en_nb, 4'hF);
        rst = 1'b0;

        scan_order();
        check_display("idle");

        drive_load(1234);
        wait_done("l1234", CONV_LEN);
        check_display("l1234");

        drive_load(7);
        wait_done("l7", CONV_LEN);
        check_display("l7");

        drive_load(10000);
        wait_done("l10000", CONV_LEN);
        check_display("l10000");

        drive_load(9999);
        wait_done("l9999", CONV_LEN);
        check_display("l9999");

        // Second strobe lands three edges into the first conversion.
        drive_load(42);
        repeat (2) @(negedge clk);
        drive_load(99);
        wait_done("l42", CONV_LEN - 3);
        check_display("l42_99");
        check_eq("l42_99_idle", busy, 1'b0);

        // Abort during conversion cycle 5.
        drive_load(1234);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        model_reset();
        check_eq("abort_busy", busy, 1'b0);
        check_eq("abort_ovf", overflow, 1'b0);
        rst = 1'b0;
        check_display("abort");

        drive_load(5);
        wait_done("l5", CONV_LEN);
        check_display("l5");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
